// File: rtl/control_unit_pkg.sv
// ============================================================================
// control_unit_pkg
// Shared definitions for the flintRV decode-stage control word: opcodes,
// field positions, immediate/ALU-op encodings and per-class control words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package control_unit_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_R       = 7'b0110011;
  localparam logic [6:0] OPC_I_JUMP  = 7'b1100111;
  localparam logic [6:0] OPC_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_I_SYS   = 7'b1110011;
  localparam logic [6:0] OPC_I_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_S       = 7'b0100011;
  localparam logic [6:0] OPC_B       = 7'b1100011;
  localparam logic [6:0] OPC_U_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_J       = 7'b1101111;

  // Control word field positions
  localparam int CTRL_REG_WRITE    = 0;
  localparam int CTRL_MEM_READ     = 1;
  localparam int CTRL_MEM_WRITE    = 2;
  localparam int CTRL_MEM_TO_REG   = 3;
  localparam int CTRL_ALU_SRC_A    = 4;
  localparam int CTRL_ALU_SRC_B    = 5;
  localparam int CTRL_BRANCH       = 6;
  localparam int CTRL_JUMP         = 7;
  localparam int CTRL_ECALL        = 8;
  localparam int CTRL_EBREAK       = 9;
  localparam int CTRL_FENCE        = 10;
  localparam int CTRL_LUI          = 11;
  localparam int CTRL_IMM_TYPE_LSB = 12;
  localparam int CTRL_IMM_TYPE_MSB = 14;
  localparam int CTRL_ALU_OP_LSB   = 15;
  localparam int CTRL_ALU_OP_MSB   = 16;

  // Immediate format selector
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // ALU operation class
  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_BRCMP = 2'd1,
    ALU_RDEC  = 2'd2,
    ALU_IDEC  = 2'd3
  } alu_op_e;

  // Per-class control words
  localparam logic [31:0] R_CTRL       = 32'h0001_0001; // REG_WRITE, ALU_OP=RDEC
  localparam logic [31:0] I_JUMP_CTRL  = 32'h0000_10A1; // REG_WRITE, JUMP, SRC_B, IMM=I
  localparam logic [31:0] I_LOAD_CTRL  = 32'h0000_102B; // REG_WRITE, MEM_READ, MEM_TO_REG, SRC_B, IMM=I
  localparam logic [31:0] I_ARITH_CTRL = 32'h0001_9021; // REG_WRITE, SRC_B, IMM=I, ALU_OP=IDEC
  localparam logic [31:0] I_SYS_CTRL   = 32'h0000_1100; // ECALL, IMM=I (EBREAK added separately)
  localparam logic [31:0] I_FENCE_CTRL = 32'h0000_0400; // FENCE
  localparam logic [31:0] S_CTRL       = 32'h0000_2024; // MEM_WRITE, SRC_B, IMM=S
  localparam logic [31:0] B_CTRL       = 32'h0000_B040; // BRANCH, IMM=B, ALU_OP=BRCMP
  localparam logic [31:0] U_LUI_CTRL   = 32'h0000_4821; // REG_WRITE, LUI, SRC_B, IMM=U
  localparam logic [31:0] U_AUIPC_CTRL = 32'h0000_4031; // REG_WRITE, SRC_A, SRC_B, IMM=U
  localparam logic [31:0] J_CTRL       = 32'h0000_50B1; // REG_WRITE, JUMP, SRC_A, SRC_B, IMM=J

  // I-type immediate field; 12'h001 under SYSTEM identifies EBREAK
  localparam logic [11:0] IMM_EBREAK = 12'h001;

  function automatic logic [11:0] imm_11_0(input logic [31:0] instr);
    return instr[31:20];
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
// ============================================================================
// control_decode
// Purely combinational opcode-to-control-word mapper for RV32I.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decode
  import control_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] ctrl_o
);

  logic [6:0] opcode;
  logic       w_unused_bits;

  assign opcode = instr_i[6:0];

  // Only the opcode and the SYSTEM immediate influence the word
  assign w_unused_bits = ^instr_i[19:7];

  // Map opcode to its control word; unknown opcodes decode to a NOP
  always_comb begin
    ctrl_o = '0;
    case (opcode)
      OPC_R:       ctrl_o = R_CTRL;
      OPC_I_JUMP:  ctrl_o = I_JUMP_CTRL;
      OPC_I_LOAD:  ctrl_o = I_LOAD_CTRL;
      OPC_I_ARITH: ctrl_o = I_ARITH_CTRL;
      OPC_I_SYS: begin
        // ECALL stays set alongside EBREAK; the trap logic prioritises EBREAK
        ctrl_o = I_SYS_CTRL;
        if (imm_11_0(instr_i) == IMM_EBREAK) begin
          ctrl_o[CTRL_EBREAK] = 1'b1;
        end
      end
      OPC_I_FENCE: ctrl_o = I_FENCE_CTRL;
      OPC_S:       ctrl_o = S_CTRL;
      OPC_B:       ctrl_o = B_CTRL;
      OPC_U_LUI:   ctrl_o = U_LUI_CTRL;
      OPC_U_AUIPC: ctrl_o = U_AUIPC_CTRL;
      OPC_J:       ctrl_o = J_CTRL;
      default:     ctrl_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit
// flintRV decode-stage control unit: registers the decoded control word,
// one cycle after the instruction is presented. Reset clears to a NOP.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
  import control_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_instr,
  output logic [31:0] o_ctrlSigs
);

  logic [31:0] ctrl_d;
  logic [31:0] ctrl_q;

  control_decode u_decode (
    .instr_i (i_instr),
    .ctrl_o  (ctrl_d)
  );

  // Output register; synchronous active-low reset forces a NOP word
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign o_ctrlSigs = ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit
// Self-checking bench for control_unit: directed cases plus random
// instruction words compared against a table-driven reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] instr;
  logic [31:0] ctrl;

  int n_checks = 0;
  int n_errs   = 0;

  control_unit dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_instr    (instr),
    .o_ctrlSigs (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the architectural control word for an instruction
  function automatic logic [31:0] model(input logic [31:0] ins);
    logic [31:0] w;
    case (ins[6:0])
      7'h33:   w = 32'h00010001;
      7'h67:   w = 32'h000010A1;
      7'h03:   w = 32'h0000102B;
      7'h13:   w = 32'h00019021;
      7'h73:   w = (ins[31:20] == 12'd1) ? 32'h00001300 : 32'h00001100;
      7'h0F:   w = 32'h00000400;
      7'h23:   w = 32'h00002024;
      7'h63:   w = 32'h0000B040;
      7'h37:   w = 32'h00004821;
      7'h17:   w = 32'h00004031;
      7'h6F:   w = 32'h000050B1;
      default: w = 32'h00000000;
    endcase
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Present one instruction for one edge and check the registered result
  task automatic cycle(input logic [31:0] ins, input logic rn, input string tag);
    instr = ins;
    rstn  = rn;
    @(posedge clk);
    #1;
    check(tag, ctrl, rn ? model(ins) : 32'h0);
  endtask

  logic [6:0] valid_ops [11] = '{7'h33, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F,
                                  7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  initial begin
    logic [31:0] r;
    rstn  = 1'b0;
    instr = 32'h0;

    // Reset holds the output at NOP even with a valid instruction present
    cycle(32'h00000033, 1'b0, "reset_hold0");
    cycle(32'h00000033, 1'b0, "reset_hold1");
    check("reset_zero", ctrl, 32'h0);
    cycle(32'h00000033, 1'b1, "reset_release");
    check("release_r_word", ctrl, 32'h00010001);

    // Full opcode sweep
    for (int i = 0; i < 128; i++) begin
      cycle(32'(i), 1'b1, $sformatf("sweep_%02h", i));
    end

    // SYSTEM immediate handling
    cycle(32'h00100073, 1'b1, "ebreak");
    check("ebreak_word", ctrl, 32'h00001300);
    cycle(32'h00000073, 1'b1, "ecall");
    check("ecall_word", ctrl, 32'h00001100);
    cycle(32'h00200073, 1'b1, "sys_imm2");
    cycle(32'h00100072, 1'b1, "ebreak_bad_opc");

    // Upper-bit independence
    cycle(32'hFFFFF0B3, 1'b1, "upper_r");
    check("upper_r_word", ctrl, 32'h00010001);
    cycle(32'hABCDE037, 1'b1, "upper_lui");
    check("upper_lui_word", ctrl, 32'h00004821);
    cycle(32'hFFFFFF83, 1'b1, "upper_load");
    check("upper_load_word", ctrl, 32'h0000102B);

    // Back-to-back decode
    cycle(32'h00000063, 1'b1, "b2b_branch");
    check("b2b_branch_word", ctrl, 32'h0000B040);
    cycle(32'h0000006F, 1'b1, "b2b_jal");
    check("b2b_jal_word", ctrl, 32'h000050B1);
    cycle(32'h00000023, 1'b1, "b2b_store");
    check("b2b_store_word", ctrl, 32'h00002024);

    // Mid-stream reset during a JAL stream
    cycle(32'h0000006F, 1'b1, "jal_stream0");
    cycle(32'h0000006F, 1'b0, "jal_midreset");
    check("midreset_zero", ctrl, 32'h0);
    cycle(32'h0000006F, 1'b1, "jal_resume");
    check("resume_jal_word", ctrl, 32'h000050B1);

    // Random stimulus, mostly legal opcodes with random upper bits
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(3) != 0) r[6:0] = valid_ops[$urandom_range(10)];
      if (r[6:0] == 7'h73 && $urandom_range(1) == 1) r[31:20] = 12'h001;
      cycle(r, ($urandom_range(15) != 0), $sformatf("rand_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
